nmx1_access_arbiter: RTL and testbench
======================================

NMX1_ACCESS_ARBITER -- requirements
Module: nmx1_access_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 65535, max cycles waited for macro func_ack per transaction.
REQ-002 Parameter MAX_PEND, default 32, capacity of the macro's write/read queue.
REQ-003 CLKin  input  1  single clock; all logic on rising edge.
REQ-004 RSTin  input  1  reset, asynchronous assert, active-low.
REQ-005 req0/req1  input  1  requester 0 (host) / 1 (DMA) transaction request, held until ack or err.
REQ-006 r_wb0/r_wb1  input  1  1 = write, 0 = read, per requester.
REQ-007 addr0/addr1  input  32  macro address; wdata0/wdata1 input 32; sel0/sel1 input 4.
REQ-008 ack0/ack1  output  1  one-cycle completion pulse; err0/err1 output 1 one-cycle failure pulse.
REQ-009 rdata  output  32  read data, valid in the ack cycle and held until the next read completes.
REQ-010 mac_en, mac_r_wb  output  1  macro EN / R_WB; mac_di, mac_ad output 32; mac_sel output 4.
REQ-011 mac_do  input  32  macro DO; mac_ack input 1 macro func_ack.
REQ-012 busy  output  1  FSM not in IDLE; pend_cnt output 6 outstanding written entries (0..MAX_PEND).

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT_ACK, DONE, FAIL.
REQ-014 IDLE: when any req is high, grant round-robin; the last-granted requester gets lowest priority; after reset requester 0 has priority.
REQ-015 IDLE, granted write while pend_cnt == MAX_PEND, or granted read while pend_cnt == 0: go to FAIL without asserting mac_en.
REQ-016 IDLE, otherwise: latch r_wb, addr, wdata, sel of the granted requester into mac_* and go to ISSUE next cycle.
REQ-017 ISSUE: mac_en = 1 for this cycle; timeout counter cleared; next state WAIT_ACK.
REQ-018 WAIT_ACK: mac_en held at 1 and mac_* stable until mac_ack = 1, then mac_en = 0 and go to DONE.
REQ-019 WAIT_ACK: counter increments each cycle; reaching TIMEOUT_CYC without mac_ack: mac_en = 0, go to FAIL.
REQ-020 mac_ack is ignored in IDLE, ISSUE, DONE and FAIL.
REQ-021 DONE: pulse ack of the granted requester for one cycle; on a read, rdata <= mac_do captured in the mac_ack cycle; return to IDLE.
REQ-022 FAIL: pulse err of the granted requester for one cycle; rdata and pend_cnt unchanged; return to IDLE.
REQ-023 pend_cnt +1 on a completed write and -1 on a completed read, updated in the DONE cycle; it never wraps.
REQ-024 Minimum transaction latency is req to ack in 4 cycles (IDLE, ISSUE, WAIT_ACK with immediate ack, DONE); err on a full/empty reject arrives in 2 cycles.
REQ-025 A requester dropping req mid-transaction does not abort it; the ack/err pulse is still issued.
REQ-026 Both req high in the same IDLE cycle: exactly one is granted per REQ-014; the other waits and is granted on the next IDLE cycle.

Reset
REQ-027 On RSTin low, regardless of clock: state IDLE, mac_en = 0, mac_r_wb = 0, mac_di/mac_ad/mac_sel = 0, ack0/ack1/err0/err1 = 0, rdata = 0, pend_cnt = 0, busy = 0, timeout counter = 0, priority to requester 0.
REQ-028 Reset during WAIT_ACK abandons the transaction; no ack or err is issued for it.

Structure
REQ-029 Shared package nmx1_pkg holds the FSM state encoding, the MAX_PEND default and the pend_cnt width constant.
REQ-030 One sub-module, nmx1_rr_grant: two-input round-robin grant with a last-grant register.

Verification
REQ-031 Host write addr 0x0420_0000, wdata 0x5A, with a 3-cycle mac_ack delay -> mac_en high 4 cycles, ack0 pulses once, pend_cnt 0->1.
REQ-032 Read after REQ-031, mac_do = 0x5A -> ack0 pulses, rdata = 0x0000_005A, pend_cnt 1->0.
REQ-033 Read at pend_cnt 0 -> err pulses 2 cycles after req, mac_en never asserted; 32 writes followed by a 33rd -> 33rd gets err, pend_cnt stays 32.
REQ-034 req0 and req1 high together, repeated -> grants alternate 0,1,0,1; each requester gets exactly one ack per request.
REQ-035 TIMEOUT_CYC = 16, mac_ack tied low -> err after 16 WAIT_ACK cycles, mac_en drops, pend_cnt unchanged.
REQ-036 RSTin low in WAIT_ACK -> all outputs reach reset values asynchronously; no ack/err issued for the abandoned transaction; the next request completes normally.

Source files
------------

// File: rtl/nmx1_pkg.sv
// nmx1_pkg: FSM encoding and sizing constants shared by the nmx1 access arbiter
package nmx1_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_DONE, S_FAIL} state_t;
  localparam int MAX_PEND_DEF = 32;
  localparam int PEND_W = 6;
endpackage

// File: rtl/nmx1_rr_grant.sv
// nmx1_rr_grant: two-input round-robin grant; the last winner loses the next tie
module nmx1_rr_grant (
  input  logic       CLKin,
  input  logic       RSTin,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       any
);
  logic last;
  assign any = |req;
  assign gnt = &req ? ~last : req[1];
  // remember the winner; reset value 1 hands the first tie to requester 0
  always_ff @(posedge CLKin or negedge RSTin)
    if (!RSTin) last <= 1'b1;
    else if (take && any) last <= gnt;
endmodule

// File: rtl/nmx1_access_arbiter.sv
// nmx1_access_arbiter: arbitrates host/DMA requests onto a single macro port with queue-depth and timeout checks
module nmx1_access_arbiter
  import nmx1_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic              CLKin,
  input  logic              RSTin,
  input  logic              req0,
  input  logic              req1,
  input  logic              r_wb0,
  input  logic              r_wb1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        sel0,
  input  logic [3:0]        sel1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              mac_en,
  output logic              mac_r_wb,
  output logic [31:0]       mac_di,
  output logic [31:0]       mac_ad,
  output logic [3:0]        mac_sel,
  input  logic [31:0]       mac_do,
  input  logic              mac_ack,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_nx;
  logic gidx, gnt, any, g_wb, rej, to_hit;
  logic [TW-1:0] to_cnt;
  nmx1_rr_grant u_rr (
    .CLKin(CLKin),
    .RSTin(RSTin),
    .req  ({req1, req0}),
    .take (state == S_IDLE),
    .gnt  (gnt),
    .any  (any)
  );
  assign g_wb   = gnt ? r_wb1 : r_wb0;
  assign rej    = g_wb ? (pend_cnt == PEND_W'(MAX_PEND)) : (pend_cnt == '0);
  assign to_hit = to_cnt == TW'(TIMEOUT_CYC - 1);
  assign mac_en = state == S_ISSUE || state == S_WAIT_ACK;
  assign busy   = state != S_IDLE;
  assign ack0   = state == S_DONE && !gidx;
  assign ack1   = state == S_DONE && gidx;
  assign err0   = state == S_FAIL && !gidx;
  assign err1   = state == S_FAIL && gidx;
  // next-state: full/empty rejects bypass the macro, timeouts end in FAIL
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (any) state_nx = rej ? S_FAIL : S_ISSUE;
      S_ISSUE:    state_nx = S_WAIT_ACK;
      S_WAIT_ACK: state_nx = mac_ack ? S_DONE : to_hit ? S_FAIL : S_WAIT_ACK;
      default:    state_nx = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge CLKin or negedge RSTin)
    if (!RSTin) state <= S_IDLE;
    else state <= state_nx;
  // latch the winner and its command on an accepted grant
  always_ff @(posedge CLKin or negedge RSTin)
    if (!RSTin) begin
      gidx     <= 1'b0;
      mac_r_wb <= 1'b0;
      mac_ad   <= '0;
      mac_di   <= '0;
      mac_sel  <= '0;
    end else if (state == S_IDLE && any) begin
      gidx <= gnt;
      if (!rej) begin
        mac_r_wb <= g_wb;
        mac_ad   <= gnt ? addr1 : addr0;
        mac_di   <= gnt ? wdata1 : wdata0;
        mac_sel  <= gnt ? sel1 : sel0;
      end
    end
  // timeout counter: cleared on issue, counts every WAIT_ACK cycle
  always_ff @(posedge CLKin or negedge RSTin)
    if (!RSTin) to_cnt <= '0;
    else if (state == S_ISSUE) to_cnt <= '0;
    else if (state == S_WAIT_ACK) to_cnt <= to_cnt + 1'b1;
  // read data is taken in the mac_ack cycle and held until the next read
  always_ff @(posedge CLKin or negedge RSTin)
    if (!RSTin) rdata <= '0;
    else if (state == S_WAIT_ACK && mac_ack && !mac_r_wb) rdata <= mac_do;
  // outstanding-entry count moves only on completed transactions
  always_ff @(posedge CLKin or negedge RSTin)
    if (!RSTin) pend_cnt <= '0;
    else if (state == S_DONE) pend_cnt <= mac_r_wb ? pend_cnt + 1'b1 : pend_cnt - 1'b1;
endmodule

// File: tb/tb_nmx1_access_arbiter.sv
// tb_nmx1_access_arbiter: scoreboard bench for the nmx1 access arbiter with a behavioural macro
module tb_nmx1_access_arbiter;
  localparam int TO = 16;
  logic CLKin = 1'b0, RSTin = 1'b0;
  logic req0 = 0, req1 = 0, r_wb0 = 0, r_wb1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [3:0] sel0 = 0, sel1 = 0;
  logic ack0, ack1, err0, err1, mac_en, mac_r_wb, busy;
  logic [31:0] rdata, mac_di, mac_ad;
  logic [3:0] mac_sel;
  logic [5:0] pend_cnt;
  logic [31:0] mac_do = 0;
  logic mac_ack = 0;
  always #5 CLKin = ~CLKin;
  nmx1_access_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .CLKin(CLKin), .RSTin(RSTin),
    .req0(req0), .req1(req1), .r_wb0(r_wb0), .r_wb1(r_wb1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .sel0(sel0), .sel1(sel1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata(rdata),
    .mac_en(mac_en), .mac_r_wb(mac_r_wb), .mac_di(mac_di), .mac_ad(mac_ad),
    .mac_sel(mac_sel), .mac_do(mac_do), .mac_ack(mac_ack),
    .busy(busy), .pend_cnt(pend_cnt)
  );
  typedef struct {logic who; logic err; logic [31:0] rd; logic [5:0] pend;} exp_t;
  exp_t sbq[$];
  exp_t me;
  int n_vec = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  // macro: acks ack_dly cycles after the issue cycle (0 = never), stores writes
  logic [31:0] mem[logic [31:0]];
  int ack_dly = 1, en_cnt = 0, en_hi = 0;
  logic [31:0] lad = 0, ldi = 0;
  always @(negedge CLKin) begin
    if (mac_en) begin
      en_cnt++;
      en_hi++;
    end else en_cnt = 0;
    mac_ack = mac_en && ack_dly != 0 && en_cnt == ack_dly + 1;
    mac_do = 32'hDEAD_BEEF;
    if (mac_ack) begin
      lad = mac_ad;
      ldi = mac_di;
      if (mac_r_wb) mem[mac_ad] = mac_di;
      else mac_do = mem.exists(mac_ad) ? mem[mac_ad] : 32'h0;
    end
  end
  // reference model of grant order, queue depth and read data
  logic [31:0] smem[logic [31:0]];
  int mpend = 0;
  logic mlast = 1'b1;
  logic [31:0] mrd = 0;
  task automatic predict(input logic who, input logic wr, input logic [31:0] a, input logic [31:0] d, input logic tmo);
    exp_t e;
    mlast = who;
    e.who = who;
    e.err = tmo || (wr ? mpend == 32 : mpend == 0);
    if (!e.err && wr) begin
      mpend++;
      smem[a] = d;
    end
    if (!e.err && !wr) begin
      mpend--;
      mrd = smem.exists(a) ? smem[a] : 32'h0;
    end
    e.rd = mrd;
    e.pend = 6'(mpend);
    sbq.push_back(e);
  endtask
  // monitor: pop on every ack/err pulse, check pend_cnt one cycle later
  logic pchk = 0;
  logic [5:0] ppend = 0;
  always @(negedge CLKin) begin
    if (pchk) begin
      chk("pend_cnt", 32'(pend_cnt), 32'(ppend));
      pchk = 0;
    end
    if (ack0 | ack1 | err0 | err1) begin
      if (sbq.size() == 0) chk("unexpected pulse", {28'h0, ack1, ack0, err1, err0}, 0);
      else begin
        me = sbq.pop_front();
        chk("single pulse", $countones({ack0, ack1, err0, err1}), 1);
        chk("requester", 32'(ack1 | err1), 32'(me.who));
        chk("err kind", 32'(err0 | err1), 32'(me.err));
        chk("rdata", rdata, me.rd);
        ppend = me.pend;
        pchk = 1;
      end
    end
  end
  task automatic xact(input logic who, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input int dly, input int lat, input int en_exp, input logic tmo);
    int c = 0, e0;
    logic seen = 0;
    @(negedge CLKin);
    ack_dly = dly;
    predict(who, wr, a, d, tmo);
    e0 = en_hi;
    if (who) begin
      req1 = 1; r_wb1 = wr; addr1 = a; wdata1 = d; sel1 = 4'hF;
    end else begin
      req0 = 1; r_wb0 = wr; addr0 = a; wdata0 = d; sel0 = 4'hF;
    end
    while (!seen && c < TO + 40) begin
      @(negedge CLKin);
      c++;
      seen = who ? (ack1 | err1) : (ack0 | err0);
    end
    req0 = 0;
    req1 = 0;
    chk("latency", c, lat);
    chk("mac_en cycles", en_hi - e0, en_exp);
  endtask
  task automatic xact2(input logic [31:0] a0, input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1);
    int c = 0;
    logic s0 = 0, s1 = 0;
    logic first;
    @(negedge CLKin);
    ack_dly = 1;
    first = ~mlast;
    if (first) begin
      predict(1, 1, a1, d1, 0);
      predict(0, 1, a0, d0, 0);
    end else begin
      predict(0, 1, a0, d0, 0);
      predict(1, 1, a1, d1, 0);
    end
    req0 = 1; r_wb0 = 1; addr0 = a0; wdata0 = d0;
    req1 = 1; r_wb1 = 1; addr1 = a1; wdata1 = d1;
    while (!(s0 && s1) && c < 60) begin
      @(negedge CLKin);
      c++;
      if (ack0 | err0) begin s0 = 1; req0 = 0; end
      if (ack1 | err1) begin s1 = 1; req1 = 0; end
    end
    req0 = 0;
    req1 = 0;
    chk("dual both served", {30'h0, s1, s0}, 3);
  endtask
  initial begin
    repeat (2) @(negedge CLKin);
    chk("reset busy", 32'(busy), 0);
    chk("reset mac_en", 32'(mac_en), 0);
    chk("reset pend", 32'(pend_cnt), 0);
    chk("reset rdata", rdata, 0);
    RSTin = 1;
    xact(0, 0, 32'h0000_0100, 0, 1, 1, 0, 0);
    xact(0, 1, 32'h0420_0000, 32'h5A, 3, 5, 4, 0);
    chk("write mac_ad", lad, 32'h0420_0000);
    chk("write mac_di", ldi, 32'h5A);
    xact(0, 0, 32'h0420_0000, 0, 1, 3, 2, 0);
    xact(1, 1, 32'h0000_2000, 32'h1111_2222, 2, 4, 3, 0);
    for (int i = 0; i < 3; i++)
      xact2(32'h3000 + 32'(i) * 8, 32'hA000 + 32'(i), 32'h3004 + 32'(i) * 8, 32'hB000 + 32'(i));
    for (int i = 0; mpend < 32; i++)
      xact(i[0], 1, 32'h1000 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i), 1, 3, 2, 0);
    @(negedge CLKin);
    chk("pend full", 32'(pend_cnt), 32);
    xact(0, 1, 32'h0000_5000, 32'hFFFF_0000, 1, 1, 0, 0);
    xact(1, 0, 32'h1000, 0, 2, 4, 3, 0);
    xact(0, 0, 32'h1004, 0, 0, TO + 2, TO + 1, 1);
    @(negedge CLKin);
    ack_dly = 0;
    req0 = 1; r_wb0 = 1; addr0 = 32'h0000_7000; wdata0 = 32'h7777; sel0 = 4'h3;
    repeat (4) @(negedge CLKin);
    chk("pre-reset busy", 32'(busy), 1);
    chk("pre-reset mac_en", 32'(mac_en), 1);
    #2 RSTin = 0;
    #1;
    chk("async mac_en", 32'(mac_en), 0);
    chk("async busy", 32'(busy), 0);
    chk("async mac_ad", mac_ad, 0);
    chk("async mac_di", mac_di, 0);
    chk("async mac_sel", 32'(mac_sel), 0);
    chk("async mac_r_wb", 32'(mac_r_wb), 0);
    chk("async pend", 32'(pend_cnt), 0);
    chk("async rdata", rdata, 0);
    chk("async pulses", {28'h0, ack1, ack0, err1, err0}, 0);
    req0 = 0;
    repeat (2) @(negedge CLKin);
    RSTin = 1;
    mpend = 0; mlast = 1; mrd = 0; smem.delete();
    xact(0, 1, 32'h0000_8000, 32'h0BAD_F00D, 1, 3, 2, 0);
    xact(1, 0, 32'h0000_8000, 0, 1, 3, 2, 0);
    repeat (2) @(negedge CLKin);
    chk("scoreboard drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
